// File: rtl/alu_pkg.sv
// Shared ALU control codes and execute-FSM encoding.
// Imported by the ALU and the decoder so both ends agree.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_ILL = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_unit_shifter.sv
// Bit-serial shifter: one position per enabled cycle.
// done flags the cycle whose step is the last one.
module alu_serial_shifter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic               dir,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WIDTH-1:0]   data,
    output logic               done
);

    logic [SHAMT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= din;
            cnt  <= shamt;
        end else if (en && (cnt != '0)) begin
            // dir=1 is a logical right shift, dir=0 is left
            data <= dir ? (data >> 1) : (data << 1);
            cnt  <= cnt - SHAMT_W'(1);
        end
    end

    assign done = (cnt == SHAMT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake.
// Logic/arith ops take one cycle; shifts run bit-serially.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [2:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             illegal
);

    alu_state_t         state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   sh_data;
    logic [SHAMT_W-1:0] shamt;
    logic               sh_done;
    logic               accept;

    assign shamt  = SrcB[SHAMT_W-1:0];
    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            (ALUControl == ALU_ADD): alu_res = SrcA + SrcB;
            (ALUControl == ALU_SUB): alu_res = SrcA - SrcB;
            (ALUControl == ALU_XOR): alu_res = SrcA ^ SrcB;
            (ALUControl == ALU_OR):  alu_res = SrcA | SrcB;
            (ALUControl == ALU_AND): alu_res = SrcA & SrcB;
            (ALUControl == ALU_ILL): alu_res = '0;
            (ALUControl == ALU_SLL): alu_res = '0;
            (ALUControl == ALU_SRL): alu_res = '0;
            default:                 alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= ALU_ADD;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= ALUControl;
                res_q <= alu_res;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_shift(ALUControl) && (shamt != '0))
                        state_d = SHIFT;
                    else
                        state_d = DONE;
                end
            end
            SHIFT: begin
                if (sh_done)
                    state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    alu_serial_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .en    (state_q == SHIFT),
        .dir   (op_q == ALU_SRL),
        .din   (SrcA),
        .shamt (shamt),
        .data  (sh_data),
        .done  (sh_done)
    );

    // Shift results live in the shifter's working register
    assign ALUResult = is_shift(op_q) ? sh_data : res_q;
    assign Zero      = out_valid && (ALUResult == '0);
    assign illegal   = out_valid && (op_q == ALU_ILL);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit.
// Hand-computed vectors; latency counted from the accept edge.
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Zero;
    logic        illegal;

    int checks = 0;
    int passed = 0;
    int lat;
    int low;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .illegal    (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Present one op at a negedge; returns at the negedge after accept
    task automatic send(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        ALUControl = op;
        SrcA       = a;
        SrcB       = b;
        in_valid   = 1'b1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        SrcA       = ~a;
        SrcB       = ~b;
        ALUControl = ~op;
        @(negedge clk);
    endtask

    task automatic wait_out(output int l, output int lo);
        l  = 1;
        lo = 0;
        while (!out_valid && l < 64) begin
            if (!in_ready) lo++;
            @(negedge clk);
            l++;
        end
        if (!in_ready) lo++;
    endtask

    task automatic run(input string tag, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat,
                       input logic ez, input logic eill);
        send(op, a, b);
        wait_out(lat, low);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, ALUResult, exp);
        chk({tag, "_zero"}, 32'(Zero), 32'(ez));
        chk({tag, "_ill"}, 32'(illegal), 32'(eill));
        @(negedge clk);
        chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = ALU_ADD;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", ALUResult, 32'd0);
        chk("rst_zero", 32'(Zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run("add", ALU_ADD, 32'h0000_0005, 32'h0000_0003,
            32'h0000_0008, 1, 1'b0, 1'b0);
        run("sub_eq", ALU_SUB, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
            32'h0000_0000, 1, 1'b1, 1'b0);
        run("sub_wrap", ALU_SUB, 32'h0000_0000, 32'h0000_0001,
            32'hFFFF_FFFF, 1, 1'b0, 1'b0);
        run("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001,
            32'h0000_0000, 1, 1'b1, 1'b0);
        run("or", ALU_OR, 32'h1200_0034, 32'h0056_7800,
            32'h1256_7834, 1, 1'b0, 1'b0);

        send(ALU_SLL, 32'h0000_0001, 32'h0000_001F);
        wait_out(lat, low);
        chk("sll31_lat", 32'(lat), 32'd32);
        chk("sll31_busy", 32'(low), 32'd32);
        chk("sll31_res", ALUResult, 32'h8000_0000);
        @(negedge clk);
        chk("sll31_rdy", 32'(in_ready), 32'd1);

        run("srl4", ALU_SRL, 32'h8000_0000, 32'h0000_0004,
            32'h0800_0000, 5, 1'b0, 1'b0);
        run("srl_mask", ALU_SRL, 32'hF000_000F, 32'hFFFF_FFE1,
            32'h7800_0007, 2, 1'b0, 1'b0);
        run("sll0", ALU_SLL, 32'h1234_5678, 32'hFFFF_FFE0,
            32'h1234_5678, 1, 1'b0, 1'b0);

        out_ready = 1'b0;
        send(ALU_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_out(lat, low);
        chk("xor_lat", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("xor_hold_valid", 32'(out_valid), 32'd1);
            chk("xor_hold_res", ALUResult, 32'h0F0F_F0F0);
            chk("xor_hold_rdy", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        chk("xor_still_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("xor_vdrop", 32'(out_valid), 32'd0);
        chk("xor_rdy", 32'(in_ready), 32'd1);

        run("ill", ALU_ILL, 32'h1234_5678, 32'h9ABC_DEF0,
            32'h0000_0000, 1, 1'b1, 1'b1);
        run("and", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0,
            32'h0F00_0F00, 1, 1'b0, 1'b0);

        send(ALU_SLL, 32'h0000_0001, 32'h0000_0014);
        repeat (5) @(negedge clk);
        chk("abort_pre_valid", 32'(out_valid), 32'd0);
        chk("abort_pre_rdy", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_res", ALUResult, 32'd0);
        chk("abort_zero", 32'(Zero), 32'd0);
        @(negedge clk);
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        run("add_after", ALU_ADD, 32'h0000_0007, 32'h0000_0009,
            32'h0000_0010, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
